// File: rtl/sr_ctrl_pkg.sv
// Shared types and default constants for the SR command arbiter.
package sr_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE_S  = 2'd1,
    ISSUE_R  = 2'd2,
    CONFLICT = 2'd3
  } sr_state_e;

  localparam int SR_SYNC_STAGES_DEF = 2;
  localparam int SR_DEBOUNCE_DEF    = 4;

endpackage

// File: rtl/sr_cmd_arbiter_if.sv
// Raw button inputs and clean SR command/status outputs of the arbiter.
interface sr_cmd_arbiter_if;
  logic set_in;
  logic reset_in;
  logic s_out;
  logic r_out;
  logic conflict;
  logic set_lvl;
  logic rst_lvl;

  modport slave (
    input  set_in, reset_in,
    output s_out, r_out, conflict, set_lvl, rst_lvl
  );

  modport master (
    output set_in, reset_in,
    input  s_out, r_out, conflict, set_lvl, rst_lvl
  );
endinterface

// File: rtl/sr_debounce.sv
// One request channel: synchroniser, debounce counter, debounced level and
// rising-edge detect producing a single-cycle request per press.
module sr_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic lvl,
  output logic req
);

  logic [SYNC_STAGES-1:0] sync_p;
  logic [CNT_W-1:0]       cnt;
  logic                   lvl_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p <= '0;
      cnt    <= '0;
      lvl    <= 1'b0;
      lvl_p1 <= 1'b0;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], din};
      lvl_p1 <= lvl;
      // The counter only runs while the synchronised input disagrees with the level.
      if (sync_p[SYNC_STAGES-1] == lvl) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        cnt <= '0;
        lvl <= ~lvl;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign req = lvl & ~lvl_p1;

endmodule

// File: rtl/sr_cmd_arbiter.sv
// Turns bouncy set/reset buttons into exclusive one-cycle s/r commands.
// Build option SR_RESET_PRIORITY_EN: a simultaneous press issues reset with the conflict pulse.
module sr_cmd_arbiter
  import sr_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES     = SR_SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = SR_DEBOUNCE_DEF,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  sr_cmd_arbiter_if.slave  cmd
);

`ifdef SR_RESET_PRIORITY_EN
  localparam bit RST_WINS = 1'b1;
`else
  localparam bit RST_WINS = 1'b0;
`endif

  logic set_lvl, rst_lvl;
  logic set_req, rst_req;

  sr_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_set_db (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (cmd.set_in),
    .lvl   (set_lvl),
    .req   (set_req)
  );

  sr_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_rst_db (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (cmd.reset_in),
    .lvl   (rst_lvl),
    .req   (rst_req)
  );

  sr_state_e state, state_nxt;
  logic      pend_s, pend_r, pend_s_nxt, pend_r_nxt;
  logic      s_q, r_q, c_q;
  logic      s_nxt, r_nxt, c_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pend_s <= 1'b0;
      pend_r <= 1'b0;
      s_q    <= 1'b0;
      r_q    <= 1'b0;
      c_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      pend_s <= pend_s_nxt;
      pend_r <= pend_r_nxt;
      s_q    <= s_nxt;
      r_q    <= r_nxt;
      c_q    <= c_nxt;
    end
  end

  // IDLE consumes everything it sees; busy states only accumulate new presses.
  always_comb begin
    state_nxt  = state;
    pend_s_nxt = pend_s | set_req;
    pend_r_nxt = pend_r | rst_req;
    case (state)
      IDLE: begin
        pend_s_nxt = 1'b0;
        pend_r_nxt = 1'b0;
        if ((set_req | pend_s) && (rst_req | pend_r)) state_nxt = CONFLICT;
        else if (set_req | pend_s)                    state_nxt = ISSUE_S;
        else if (rst_req | pend_r)                    state_nxt = ISSUE_R;
      end
      default: state_nxt = IDLE;
    endcase
    s_nxt = (state_nxt == ISSUE_S);
    r_nxt = (state_nxt == ISSUE_R) || (RST_WINS && state_nxt == CONFLICT);
    c_nxt = (state_nxt == CONFLICT);
  end

  assign cmd.s_out    = s_q;
  assign cmd.r_out    = r_q;
  assign cmd.conflict = c_q;
  assign cmd.set_lvl  = set_lvl;
  assign cmd.rst_lvl  = rst_lvl;

  a_no_sr_overlap: assert property (@(posedge clk) disable iff (!rst_n) !(s_q && r_q));

endmodule

// File: tb/tb_sr_cmd_arbiter.sv
// Bench for sr_cmd_arbiter: directed scenarios plus random bouncy inputs vs a look-back model.
module tb_sr_cmd_arbiter;
  import sr_ctrl_pkg::*;

  localparam int SYNC = SR_SYNC_STAGES_DEF;
  localparam int DEB  = SR_DEBOUNCE_DEF;
`ifdef SR_RESET_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sr_cmd_arbiter_if cmd();

  sr_cmd_arbiter #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cmd   (cmd)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: raw sample history, levels derived by looking back over it.
  logic [1:0] raw_q[$];
  int  e;
  bit  lvl[2];
  int  lf[2];
  bit  req[2];
  bit  pend_s, pend_r, busy;
  bit  m_s, m_r, m_c;

  int cnt_s, cnt_r, cnt_c, e_s, e_r, e_c, e_sl, e_rl;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit samp(input int ch, input int k);
    logic [1:0] v;
    int idx;
    idx = k - SYNC;
    if (idx < 1) return 1'b0;
    v = raw_q[idx-1];
    return v[ch];
  endfunction

  task automatic model_reset();
    e = 0;
    raw_q.delete();
    for (int c = 0; c < 2; c++) begin
      lvl[c] = 1'b0; lf[c] = 0; req[c] = 1'b0;
    end
    pend_s = 1'b0; pend_r = 1'b0; busy = 1'b0;
    m_s = 1'b0; m_r = 1'b0; m_c = 1'b0;
  endtask

  task automatic upd_lvl(input int ch);
    int n, k;
    n = 0;
    k = e;
    while (n < DEB && k > lf[ch] && samp(ch, k) != lvl[ch]) begin
      n++;
      k--;
    end
    req[ch] = 1'b0;
    if (n == DEB) begin
      req[ch] = !lvl[ch];
      lvl[ch] = !lvl[ch];
      lf[ch]  = e;
    end
  endtask

  task automatic model_edge();
    bit ps, pr;
    e++;
    raw_q.push_back({cmd.reset_in, cmd.set_in});
    m_s = 1'b0; m_r = 1'b0; m_c = 1'b0;
    if (busy) begin
      pend_s = pend_s | req[0];
      pend_r = pend_r | req[1];
      busy   = 1'b0;
    end else begin
      ps = pend_s | req[0];
      pr = pend_r | req[1];
      pend_s = 1'b0;
      pend_r = 1'b0;
      if (ps && pr) begin m_c = 1'b1; m_r = PRIO; busy = 1'b1; end
      else if (ps)  begin m_s = 1'b1; busy = 1'b1; end
      else if (pr)  begin m_r = 1'b1; busy = 1'b1; end
    end
    upd_lvl(0);
    upd_lvl(1);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("s_out", cmd.s_out, m_s);
    chk("r_out", cmd.r_out, m_r);
    chk("conflict", cmd.conflict, m_c);
    chk("set_lvl", cmd.set_lvl, lvl[0]);
    chk("rst_lvl", cmd.rst_lvl, lvl[1]);
    chk("s_and_r", cmd.s_out & cmd.r_out, 1'b0);
  endtask

  task automatic step_rst();
    @(posedge clk);
    #1;
    model_reset();
    chk("rst_s_out", cmd.s_out, 1'b0);
    chk("rst_r_out", cmd.r_out, 1'b0);
    chk("rst_conflict", cmd.conflict, 1'b0);
    chk("rst_set_lvl", cmd.set_lvl, 1'b0);
    chk("rst_rst_lvl", cmd.rst_lvl, 1'b0);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) step_rst();
    rst_n = 1'b1;
  endtask

  // Runs n edges, noting pulse counts and the first edge (1-based) of each event.
  task automatic run_rec(input int n, input int rise_r_at);
    cnt_s = 0; cnt_r = 0; cnt_c = 0;
    e_s = 0; e_r = 0; e_c = 0; e_sl = 0; e_rl = 0;
    for (int i = 1; i <= n; i++) begin
      if (i == rise_r_at) cmd.reset_in = 1'b1;
      step();
      if (cmd.s_out)    begin cnt_s++; if (e_s == 0) e_s = i; end
      if (cmd.r_out)    begin cnt_r++; if (e_r == 0) e_r = i; end
      if (cmd.conflict) begin cnt_c++; if (e_c == 0) e_c = i; end
      if (cmd.set_lvl && e_sl == 0) e_sl = i;
      if (cmd.rst_lvl && e_rl == 0) e_rl = i;
    end
  endtask

  initial begin
    int dur_s, dur_r;
    bit seen;
    cmd.set_in   = 1'b0;
    cmd.reset_in = 1'b0;
    model_reset();

    // Reset and idle
    do_reset(3);
    run_rec(20, 0);
    chkn("idle_s_cnt", cnt_s, 0);
    chkn("idle_r_cnt", cnt_r, 0);
    chkn("idle_c_cnt", cnt_c, 0);

    // Clean set press, held
    do_reset(2);
    cmd.set_in = 1'b1;
    run_rec(30, 0);
    chkn("clean_set_lvl_edge", e_sl, 6);
    chkn("clean_s_edge", e_s, 7);
    chkn("clean_s_cnt", cnt_s, 1);
    chkn("clean_r_cnt", cnt_r, 0);
    cmd.set_in = 1'b0;
    run_rec(10, 0);
    chkn("release_s_cnt", cnt_s, 0);

    // Bouncy reset press
    do_reset(2);
    cmd.reset_in = 1'b1;
    repeat (3) step();
    cmd.reset_in = 1'b0;
    step();
    cmd.reset_in = 1'b1;
    run_rec(25, 0);
    chkn("bounce_r_edge", e_r, 7);
    chkn("bounce_r_cnt", cnt_r, 1);
    chkn("bounce_s_cnt", cnt_s, 0);
    cmd.reset_in = 1'b0;

    // Simultaneous press
    do_reset(2);
    cmd.set_in = 1'b1;
    cmd.reset_in = 1'b1;
    run_rec(20, 0);
    chkn("simul_c_edge", e_c, 7);
    chkn("simul_c_cnt", cnt_c, 1);
    chkn("simul_s_cnt", cnt_s, 0);
    chkn("simul_r_cnt", cnt_r, PRIO ? 1 : 0);
    if (PRIO) chkn("simul_r_edge", e_r, 7);
    cmd.set_in = 1'b0;
    cmd.reset_in = 1'b0;

    // Back-to-back: reset one cycle after set
    do_reset(2);
    cmd.set_in = 1'b1;
    run_rec(20, 2);
    chkn("b2b_s_edge", e_s, 7);
    chkn("b2b_r_edge", e_r, 9);
    chkn("b2b_c_cnt", cnt_c, 0);
    chkn("b2b_s_cnt", cnt_s, 1);
    chkn("b2b_r_cnt", cnt_r, 1);
    cmd.set_in = 1'b0;
    cmd.reset_in = 1'b0;

    // Reset dropped while s_out is high
    do_reset(2);
    cmd.set_in = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      seen = cmd.s_out;
    end
    chk("midop_s_seen", seen, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midop_s_killed", cmd.s_out, 1'b0);
    cmd.set_in = 1'b0;
    model_reset();
    do_reset(2);
    run_rec(20, 0);
    chkn("midop_after_s_cnt", cnt_s, 0);
    chkn("midop_after_r_cnt", cnt_r, 0);

    // Random bouncy traffic against the model
    do_reset(2);
    dur_s = 0;
    dur_r = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset(2);
      if (dur_s <= 0) begin
        cmd.set_in = 1'($urandom_range(0, 1));
        dur_s = int'($urandom_range(1, 9));
        if ($urandom_range(0, 3) == 0) begin
          cmd.reset_in = cmd.set_in;
          dur_r = dur_s;
        end
      end
      if (dur_r <= 0) begin
        cmd.reset_in = 1'($urandom_range(0, 1));
        dur_r = int'($urandom_range(1, 9));
      end
      dur_s--;
      dur_r--;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_cmd_arbiter.md
# sr_cmd_arbiter

Upstream command stage for the SR flip-flop: converts two asynchronous, bouncy set/reset requests into clean single-cycle `s`/`r` pulses. It guarantees `s` and `r` are never asserted together, so the downstream flop never reaches its invalid 2'b11 state. Both channels are synchronised and debounced, each new press is edge-detected into one command, and simultaneous presses are resolved here.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchroniser depth per channel; legal range ≥2.
- `DEBOUNCE_CYCLES`, 4: consecutive stable cycles required before a debounced level changes; legal range ≥1.
- `CNT_W`, $clog2(DEBOUNCE_CYCLES+1): width of the debounce counter.

Ports:
- `clk`  in  1  single system clock; all logic on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `set_in`  in  1  raw set request; asynchronous to `clk`, may bounce.
- `reset_in`  in  1  raw reset request; asynchronous to `clk`, may bounce.
- `s_out`  out  1  one-cycle set command to the SR flop `s` input.
- `r_out`  out  1  one-cycle reset command to the SR flop `r` input.
- `conflict`  out  1  one-cycle pulse when set and reset resolve in the same cycle.
- `set_lvl`  out  1  debounced set level, for status.
- `rst_lvl`  out  1  debounced reset level, for status.

## Operation
Per-channel path: `SYNC_STAGES` synchroniser, then debounce, then rising-edge detection, producing a one-cycle request (`set_req` / `rst_req`).

Debounce:
- Counter clears whenever the synchronised input equals the debounced level.
- Otherwise the counter increments.
- When the counter reaches `DEBOUNCE_CYCLES`, the debounced level flips and the counter clears.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles never changes the level.

Pending bits:
- `pend_s` / `pend_r` latch any request that arrives while the FSM is not in IDLE.
- IDLE considers `set_req|pend_s` and `rst_req|pend_r`.
- The pending bit of a channel clears on the cycle its command issues, or when a conflict resolves it.

FSM states and transitions:
- IDLE, set only pending → ISSUE_S.
- IDLE, reset only pending → ISSUE_R.
- IDLE, both pending → CONFLICT.
- ISSUE_S: `s_out`=1 for exactly one cycle → IDLE.
- ISSUE_R: `r_out`=1 for exactly one cycle → IDLE.
- CONFLICT: `conflict`=1 for one cycle; resolution per Configuration → IDLE.
- All outputs are registered and decoded from the state register.
- `s_out & r_out` is never 1; this holds as an assertion.

Releases (falling edges of the debounced levels) generate no command. Holding a button produces exactly one command.

Reset:
- All sync flops, counters, debounced levels and pending bits go to 0.
- State goes to IDLE.
- `s_out`=`r_out`=`conflict`=`set_lvl`=`rst_lvl`=0.
- Reset asserted mid-pulse kills the pulse immediately (asynchronous). Any pending command is discarded.
- After reset deassertion, an input that is already held high is treated as a new press once it is debounced.

## Timing
- Latency: raw input stable high at edge 0 → `set_lvl`/`rst_lvl` high after `SYNC_STAGES+DEBOUNCE_CYCLES` edges.
- The command pulse goes high one edge later: 7 edges with the default parameters.
- Throughput: at most one command per 2 cycles (ISSUE or CONFLICT, then IDLE).
- A request arriving during ISSUE_x is served from IDLE two edges after its own request cycle.
- Set request at cycle t and reset request at t+1: `s_out` at t+1, `r_out` at t+3. They are never merged into a conflict.

## Configuration
Macro `SR_RESET_PRIORITY_EN`:
- Defined: the CONFLICT state also asserts `r_out` with `conflict` in the same cycle. Reset wins, and both pending bits clear.
- Undefined: CONFLICT asserts only `conflict`. Both requests are dropped and the flop holds.

## Structure
- Package `sr_ctrl_pkg` holds:
  - the state enum: IDLE, ISSUE_S, ISSUE_R, CONFLICT;
  - the default constants `SR_SYNC_STAGES_DEF`=2 and `SR_DEBOUNCE_DEF`=4.
- Sub-module `sr_debounce` contains synchroniser, counter, level register and rising-edge detect. It is instantiated twice, once per channel.
- The top level contains the pending bits, the FSM and the output registers.

## Test plan
- Reset and idle: `rst_n`=0 for 3 cycles with inputs at 0 → all outputs 0; after release, inputs held at 0 for 20 cycles → no pulses.
- Clean set: `set_in` 0→1 held high (defaults) → `set_lvl` high 6 edges later; `s_out`=1 for exactly one cycle at edge 7; `r_out` stays 0.
- Bounce rejection: `reset_in` toggles high for 3 cycles, low for 1, then stays high → `r_out` pulses once, 7 edges after the final rise; exactly one pulse in total.
- Simultaneous press: both inputs rise on the same edge → one `conflict` pulse at edge 7. With `SR_RESET_PRIORITY_EN`, `r_out`=1 in that same cycle; without it, `s_out`=`r_out`=0 throughout.
- Back-to-back requests: `reset_in` rises one cycle after `set_in` → `s_out` at edge 7, `r_out` at edge 9, no `conflict`.
- Reset mid-operation: `rst_n` dropped in the cycle `s_out` is high → `s_out` is 0 immediately; no command follows the release while inputs are low.
